// File: rtl/uart_tx_ctrl_pkg.sv
// Shared types and constants for the UART transmit frame controller.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    typedef enum logic [1:0] {
        SEL_START,
        SEL_DATA,
        SEL_PAR,
        SEL_STOP
    } tx_sel_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Which source owns the TX line in each state; IDLE shares the stop level.
    function automatic tx_sel_t tx_sel_of(input state_t s);
        tx_sel_t sel;
        sel = SEL_STOP;
        case (s)
            START:   sel = SEL_START;
            DATA:    sel = SEL_DATA;
            PARITY:  sel = SEL_PAR;
            default: sel = SEL_STOP;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Host request and serializer handshake bundle for uart_tx_ctrl.
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  ser_data;
    logic                  ser_done;
    logic [DATA_WIDTH-1:0] ser_pdata;
    logic                  ser_en;
    logic                  TX_OUT;
    logic                  busy;
    logic                  sync_err;

    // Host plus serializer side: drives requests and serial data.
    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_data, ser_done,
        input  ser_pdata, ser_en, TX_OUT, busy, sync_err
    );

    // Frame controller side.
    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_data, ser_done,
        output ser_pdata, ser_en, TX_OUT, busy, sync_err
    );
endinterface

// File: rtl/uart_tx_parity.sv
// Registered frame parity bit, captured when a new byte is accepted.
module uart_tx_parity #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_bit <= 1'b0;
        end else if (load) begin
            par_bit <= (^data) ^ par_typ;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART frame sequencer: start, data, optional parity, stop, one bit per CLK.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input logic          CLK,
    input logic          RST,
    uart_tx_ctrl_if.slave bus
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    tx_sel_t          tx_sel;
    logic [CNT_W-1:0] bit_cnt;
    logic             par_en_q;
    logic             par_bit;
    logic             accept;
    logic             last_data;
    logic             done_expected;

    assign last_data = (state == DATA) && (bit_cnt == LAST_BIT);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Data_Valid) begin
                    accept    = 1'b1;
                    state_nxt = START;
                end
            end
            START:  state_nxt = DATA;
            DATA: begin
                if (last_data) begin
                    state_nxt = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: state_nxt = STOP;
            STOP: begin
                if (bus.Data_Valid) begin
                    accept    = 1'b1;
                    state_nxt = START;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt <= '0;
        end else if (state == START) begin
            bit_cnt <= '0;
        end else if (state == DATA) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.ser_pdata <= '0;
            par_en_q      <= 1'b0;
        end else if (accept) begin
            bus.ser_pdata <= bus.P_DATA;
            par_en_q      <= bus.PAR_EN;
        end
    end

    // ser_done must coincide exactly with the cycle after the last data bit;
    // a missing or stray pulse both mean the serializer has slipped.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            done_expected <= 1'b0;
            bus.sync_err  <= 1'b0;
        end else begin
            done_expected <= last_data;
            bus.sync_err  <= bus.sync_err | (done_expected ^ bus.ser_done);
        end
    end

    uart_tx_parity #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .CLK     (CLK),
        .RST     (RST),
        .load    (accept),
        .data    (bus.P_DATA),
        .par_typ (bus.PAR_TYP),
        .par_bit (par_bit)
    );

    assign tx_sel     = tx_sel_of(state);
    assign bus.ser_en = (state == START) || (state == DATA);
    assign bus.busy   = (state != IDLE);

    always_comb begin
        bus.TX_OUT = STOP_BIT;
        case (tx_sel)
            SEL_START: bus.TX_OUT = START_BIT;
            SEL_DATA:  bus.TX_OUT = bus.ser_data;
            SEL_PAR:   bus.TX_OUT = par_bit;
            default:   bus.TX_OUT = STOP_BIT;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl with a behavioural 8-bit serializer and a frame-queue line model.
module tb_uart_tx_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Serializer: each enabled edge shifts out the next bit; the enable after
    // the eighth bit wraps the counter and pulses ser_done for one cycle.
    logic [3:0] s_cnt;
    logic       s_data;
    logic       s_done_raw;
    logic       kill_done  = 1'b0;
    logic       force_done = 1'b0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s_cnt      <= 4'd0;
            s_data     <= 1'b0;
            s_done_raw <= 1'b0;
        end else begin
            s_done_raw <= 1'b0;
            if (bus.ser_en) begin
                if (s_cnt == 4'd8) begin
                    s_cnt      <= 4'd0;
                    s_done_raw <= 1'b1;
                end else begin
                    s_data <= bus.ser_pdata[s_cnt[2:0]];
                    s_cnt  <= s_cnt + 4'd1;
                end
            end
        end
    end

    assign bus.ser_data = s_data;
    assign bus.ser_done = (s_done_raw & ~kill_done) | force_done;

    // Line model: one queue slot per upcoming bit time, head = current cycle.
    typedef struct packed {
        logic       tx;
        logic       en;
        logic       exp_done;
        logic [7:0] data;
    } slot_t;

    slot_t      q[$];
    logic [7:0] m_pdata;
    logic       m_err;

    function automatic void push_frame(input logic [7:0] d, input logic pe, input logic pt);
        q.push_back('{tx: 1'b0, en: 1'b1, exp_done: 1'b0, data: d});
        for (int i = 0; i < 8; i++) q.push_back('{tx: d[i], en: 1'b1, exp_done: 1'b0, data: d});
        if (pe) q.push_back('{tx: (^d) ^ pt, en: 1'b0, exp_done: 1'b1, data: d});
        q.push_back('{tx: 1'b1, en: 1'b0, exp_done: !pe, data: d});
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            q.delete();
            m_pdata = 8'h00;
            m_err   = 1'b0;
        end else begin
            int  was;
            logic cur_done;
            was      = q.size();
            cur_done = (was != 0) ? q[0].exp_done : 1'b0;
            if (cur_done != bus.ser_done) m_err = 1'b1;
            if (was != 0) void'(q.pop_front());
            if (bus.Data_Valid && was <= 1) begin
                push_frame(bus.P_DATA, bus.PAR_EN, bus.PAR_TYP);
                m_pdata = bus.P_DATA;
            end
        end
    end

    always @(negedge CLK) begin
        if (RST) begin
            logic e_tx, e_en, e_busy;
            e_busy = (q.size() != 0);
            e_tx   = e_busy ? q[0].tx : 1'b1;
            e_en   = e_busy ? q[0].en : 1'b0;
            check("line_tx", 32'(bus.TX_OUT), 32'(e_tx));
            check("line_busy", 32'(bus.busy), 32'(e_busy));
            check("line_ser_en", 32'(bus.ser_en), 32'(e_en));
            check("line_pdata", 32'(bus.ser_pdata), 32'(m_pdata));
            check("line_sync_err", 32'(bus.sync_err), 32'(m_err));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Strobe for one edge, then scramble the inputs to show the latch holds.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt);
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.Data_Valid = 1'b1;
        tick(1);
        bus.Data_Valid = 1'b0;
        bus.P_DATA     = ~d;
        bus.PAR_EN     = ~pe;
        bus.PAR_TYP    = ~pt;
    endtask

    task automatic capture(input int n, output logic [15:0] tx, output int busy_n,
                           output logic [15:0] done);
        tx     = '0;
        done   = '0;
        busy_n = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            tx[i]   = bus.TX_OUT;
            done[i] = bus.ser_done;
            if (bus.busy) busy_n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] tx;
        logic [15:0] done;
        int          busy_n;

        bus.P_DATA     = 8'h00;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;

        tick(3);
        check("rst_tx", 32'(bus.TX_OUT), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ser_en", 32'(bus.ser_en), 32'd0);
        check("rst_pdata", 32'(bus.ser_pdata), 32'd0);
        check("rst_sync_err", 32'(bus.sync_err), 32'd0);
        RST = 1'b1;
        tick(2);

        send(8'hA5, 1'b1, 1'b0);
        capture(13, tx, busy_n, done);
        check("even_a5_line", 32'(tx[12:0]), 32'h1D4A);
        check("even_a5_busy", 32'(busy_n), 32'd11);
        check("even_a5_sync", 32'(bus.sync_err), 32'd0);

        send(8'h01, 1'b1, 1'b1);
        capture(13, tx, busy_n, done);
        check("odd_01_parity", 32'(tx[9]), 32'd0);
        send(8'h03, 1'b1, 1'b1);
        capture(13, tx, busy_n, done);
        check("odd_03_parity", 32'(tx[9]), 32'd1);
        check("odd_03_busy", 32'(busy_n), 32'd11);

        send(8'hFF, 1'b0, 1'b0);
        capture(12, tx, busy_n, done);
        check("nopar_ff_line", 32'(tx[11:0]), 32'hFFE);
        check("nopar_ff_busy", 32'(busy_n), 32'd10);
        check("nopar_done_in_stop", 32'(done[11:0]), 32'h200);

        // Ignored strobe in DATA, then back-to-back strobe in STOP.
        send(8'hA5, 1'b1, 1'b0);
        tick(3);
        bus.P_DATA     = 8'h00;
        bus.Data_Valid = 1'b1;
        tick(1);
        bus.Data_Valid = 1'b0;
        tick(6);
        send(8'h3C, 1'b0, 1'b0);
        @(negedge CLK);
        check("b2b_start_tx", 32'(bus.TX_OUT), 32'd0);
        check("b2b_start_busy", 32'(bus.busy), 32'd1);
        check("b2b_pdata", 32'(bus.ser_pdata), 32'h3C);
        tick(12);

        // Asynchronous reset during data bit 3 (a 0 bit of 0xA5).
        send(8'hA5, 1'b1, 1'b0);
        tick(4);
        #2;
        check("pre_rst_bit3", 32'(bus.TX_OUT), 32'd0);
        RST = 1'b0;
        #1;
        check("midrst_tx", 32'(bus.TX_OUT), 32'd1);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_ser_en", 32'(bus.ser_en), 32'd0);
        tick(2);
        RST = 1'b1;
        tick(1);
        send(8'h5A, 1'b1, 1'b1);
        capture(13, tx, busy_n, done);
        check("after_rst_5a_line", 32'(tx[12:0]), 32'h1EB4);
        check("after_rst_5a_sync", 32'(bus.sync_err), 32'd0);

        // Missing ser_done in the cycle after the last data bit.
        send(8'hC3, 1'b1, 1'b0);
        tick(9);
        kill_done = 1'b1;
        tick(1);
        kill_done = 1'b0;
        check("align_err_set", 32'(bus.sync_err), 32'd1);
        check("align_stop_tx", 32'(bus.TX_OUT), 32'd1);
        tick(5);
        check("align_err_sticky", 32'(bus.sync_err), 32'd1);
        check("align_frame_done", 32'(bus.busy), 32'd0);
        RST = 1'b0;
        #1;
        check("align_err_cleared", 32'(bus.sync_err), 32'd0);
        tick(1);
        RST = 1'b1;
        tick(1);

        // Stray ser_done while idle.
        force_done = 1'b1;
        tick(1);
        force_done = 1'b0;
        check("stray_done_err", 32'(bus.sync_err), 32'd1);

        // Strobe present as reset releases: accepted on the first edge with RST high.
        RST = 1'b0;
        tick(2);
        RST = 1'b1;
        send(8'h81, 1'b0, 1'b0);
        capture(12, tx, busy_n, done);
        check("rst_release_81_line", 32'(tx[11:0]), 32'hF02);
        check("rst_release_sync", 32'(bus.sync_err), 32'd0);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
